// File: rtl/mms_mem_arb.sv
// Two-port cache-line memory arbiter: I-cache refills and D-cache refill/writeback
// share one single-beat memory port, round-robin granted, one line transaction in flight.
module mms_mem_arb #(
   parameter int ADDR_WD = 32,
   parameter int DATA_WD = 32,
   parameter int BEATS   = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ic_req_valid,
   output logic                     ic_req_ready,
   input  logic [ADDR_WD-1:0]       ic_req_addr,
   output logic                     ic_rsp_valid,
   output logic [BEATS*DATA_WD-1:0] ic_rsp_data,
   input  logic                     dc_req_valid,
   output logic                     dc_req_ready,
   input  logic [ADDR_WD-1:0]       dc_req_addr,
   input  logic                     dc_req_we,
   input  logic [BEATS*DATA_WD-1:0] dc_req_wdata,
   output logic                     dc_rsp_valid,
   output logic [BEATS*DATA_WD-1:0] dc_rsp_data,
   output logic                     mem_valid,
   input  logic                     mem_ready,
   output logic [ADDR_WD-1:0]       mem_addr,
   output logic                     mem_we,
   output logic [DATA_WD-1:0]       mem_wdata,
   input  logic                     mem_rvalid,
   input  logic [DATA_WD-1:0]       mem_rdata
);
   localparam int LINE_WD = BEATS * DATA_WD;
   localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int STEP    = DATA_WD / 8;
   localparam int OFF_W   = $clog2(LINE_WD / 8);
   localparam logic [ADDR_WD-1:0] OFF_MASK  = ADDR_WD'((64'd1 << OFF_W) - 64'd1);
   localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(BEATS - 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

   state_e              state_q, state_d;
   logic                owner_dc_q, owner_dc_d;
   logic                we_q, we_d;
   logic                last_dc_q, last_dc_d;
   logic [ADDR_WD-1:0]  addr_q, addr_d;
   logic [LINE_WD-1:0]  wdata_q, wdata_d;
   logic [LINE_WD-1:0]  rbuf_q, rbuf_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic                mem_valid_q, mem_valid_d;
   logic                ic_rsp_q, ic_rsp_d;
   logic                dc_rsp_q, dc_rsp_d;
   logic                grant_dc;

   // D-cache wins when it is alone or when the I-cache had the previous grant.
   assign grant_dc     = dc_req_valid && (!ic_req_valid || !last_dc_q);
   assign ic_req_ready = rst_n && (state_q == IDLE) && ic_req_valid && !grant_dc;
   assign dc_req_ready = rst_n && (state_q == IDLE) && grant_dc;

   always_comb begin
      state_d    = state_q;
      owner_dc_d = owner_dc_q;
      we_d       = we_q;
      last_dc_d  = last_dc_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rbuf_d     = rbuf_q;
      beat_d     = beat_q;
      case (state_q)
         IDLE: begin
            if (ic_req_ready || dc_req_ready) begin
               owner_dc_d = dc_req_ready;
               last_dc_d  = dc_req_ready;
               we_d       = dc_req_ready && dc_req_we;
               addr_d     = (dc_req_ready ? dc_req_addr : ic_req_addr) & ~OFF_MASK;
               wdata_d    = dc_req_ready ? dc_req_wdata : '0;
               beat_d     = '0;
               rbuf_d     = '0;
               state_d    = REQ;
            end
         end
         REQ: begin
            if (mem_ready) begin
               if (we_q) begin
                  beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_W'(1);
                  if (beat_q == LAST_BEAT) state_d = RESP;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (mem_rvalid) begin
               rbuf_d[int'(beat_q)*DATA_WD +: DATA_WD] = mem_rdata;
               beat_d  = (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_W'(1);
               state_d = (beat_q == LAST_BEAT) ? RESP : REQ;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Strobes are registered off the next state so they line up with it.
      mem_valid_d = (state_d == REQ);
      ic_rsp_d    = (state_d == RESP) && !owner_dc_d;
      dc_rsp_d    = (state_d == RESP) && owner_dc_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         owner_dc_q  <= 1'b0;
         we_q        <= 1'b0;
         last_dc_q   <= 1'b1;
         addr_q      <= '0;
         wdata_q     <= '0;
         rbuf_q      <= '0;
         beat_q      <= '0;
         mem_valid_q <= 1'b0;
         ic_rsp_q    <= 1'b0;
         dc_rsp_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_dc_q  <= owner_dc_d;
         we_q        <= we_d;
         last_dc_q   <= last_dc_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rbuf_q      <= rbuf_d;
         beat_q      <= beat_d;
         mem_valid_q <= mem_valid_d;
         ic_rsp_q    <= ic_rsp_d;
         dc_rsp_q    <= dc_rsp_d;
      end
   end

   assign mem_valid    = mem_valid_q;
   assign mem_we       = we_q;
   assign mem_addr     = addr_q + ADDR_WD'(int'(beat_q) * STEP);
   assign mem_wdata    = wdata_q[int'(beat_q)*DATA_WD +: DATA_WD];
   assign ic_rsp_valid = ic_rsp_q;
   assign dc_rsp_valid = dc_rsp_q;
   assign ic_rsp_data  = rbuf_q;
   assign dc_rsp_data  = rbuf_q;

endmodule

// File: tb/tb_mms_mem_arb.sv
// Bench for mms_mem_arb: vector table plus contention and mid-burst reset sequences,
// with a memory model and scoreboard queues checked from a negedge monitor.
module tb_mms_mem_arb;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         ic_req_valid = 1'b0;
   logic         ic_req_ready;
   logic [31:0]  ic_req_addr = '0;
   logic         ic_rsp_valid;
   logic [127:0] ic_rsp_data;
   logic         dc_req_valid = 1'b0;
   logic         dc_req_ready;
   logic [31:0]  dc_req_addr = '0;
   logic         dc_req_we = 1'b0;
   logic [127:0] dc_req_wdata = '0;
   logic         dc_rsp_valid;
   logic [127:0] dc_rsp_data;
   logic         mem_valid;
   logic         mem_ready = 1'b1;
   logic [31:0]  mem_addr;
   logic         mem_we;
   logic [31:0]  mem_wdata;
   logic         mem_rvalid = 1'b0;
   logic [31:0]  mem_rdata = '0;

   mms_mem_arb #(.ADDR_WD(32), .DATA_WD(32), .BEATS(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
      .ic_rsp_valid(ic_rsp_valid), .ic_rsp_data(ic_rsp_data),
      .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_addr(dc_req_addr),
      .dc_req_we(dc_req_we), .dc_req_wdata(dc_req_wdata),
      .dc_rsp_valid(dc_rsp_valid), .dc_rsp_data(dc_rsp_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         dc;
      logic         we;
      logic [31:0]  addr;
      logic [127:0] wdata;
      int           stall;
      logic         spur;
      int           lat;
      logic [127:0] rdata;
   } vec_t;
   typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } beat_t;
   typedef struct { logic dc; int lat; logic [127:0] data; } rsp_t;

   beat_t exp_beats[$];
   rsp_t  exp_rsps[$];
   int    acc_q[$];
   vec_t  vecs[7];

   int checks = 0, errors = 0, cyc = 0;
   int stall_left = 0, n_acc = 0;
   logic spur_en = 1'b0, pend = 1'b0, busy = 1'b0, last_dc = 1'b1, held_dc = 1'b0;
   logic [31:0]  pend_data = '0;
   logic [127:0] held = '0;
   logic  mon_stall, mon_ic, mon_dc;
   beat_t mon_b;
   rsp_t  mon_r;
   int    mon_a;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [127:0] addr_line(input logic [31:0] a);
      logic [31:0] b;
      b = a & ~32'hF;
      return {b + 32'd12, b + 32'd8, b + 32'd4, b};
   endfunction

   // Memory model (addr-as-data, rvalid the cycle after a read beat) and scoreboard.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("reset_strobes", 128'({ic_req_ready, dc_req_ready, mem_valid, mem_we, ic_rsp_valid, dc_rsp_valid}), 128'(0));
         chk("reset_mem_bus", 128'({mem_addr, mem_wdata}), 128'(0));
         chk("reset_rsp_data", ic_rsp_data | dc_rsp_data, 128'(0));
         exp_beats.delete(); exp_rsps.delete(); acc_q.delete();
         busy = 1'b0; last_dc = 1'b1; held_dc = 1'b0; held = '0;
         pend = 1'b0; mem_rvalid = 1'b0; mem_ready = 1'b1; stall_left = 0;
      end else begin
         mem_rvalid = pend;
         mem_rdata  = pend_data;
         pend       = 1'b0;
         mon_stall  = mem_valid && (mem_addr[3:0] == 4'h4) && (stall_left > 0);
         mem_ready  = !mon_stall;
         if (mon_stall) begin
            stall_left--;
            if (exp_beats.size() != 0) begin
               chk("stall_addr_stable", 128'(mem_addr), 128'(exp_beats[0].addr));
               if (exp_beats[0].we) chk("stall_wdata_stable", 128'(mem_wdata), 128'(exp_beats[0].wdata));
            end
            if (spur_en) begin
               mem_rvalid = 1'b1;
               mem_rdata  = 32'hDEAD_BEEF;
            end
         end
         if (mem_valid && mem_ready) begin
            if (exp_beats.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_beat: addr %h with none expected (cycle %0d)", mem_addr, cyc);
            end else begin
               mon_b = exp_beats.pop_front();
               chk("beat_addr", 128'(mem_addr), 128'(mon_b.addr));
               chk("beat_we", 128'(mem_we), 128'(mon_b.we));
               if (mon_b.we) chk("beat_wdata", 128'(mem_wdata), 128'(mon_b.wdata));
            end
            if (!mem_we) begin
               pend      = 1'b1;
               pend_data = mem_addr;
            end
         end
         mon_ic = !busy && ic_req_valid && (!dc_req_valid || last_dc);
         mon_dc = !busy && dc_req_valid && (!ic_req_valid || !last_dc);
         chk("req_ready", 128'({ic_req_ready, dc_req_ready}), 128'({mon_ic, mon_dc}));
         if (!busy) chk("rsp_data_held", held_dc ? dc_rsp_data : ic_rsp_data, held);
         if (ic_rsp_valid || dc_rsp_valid) begin
            if (ic_rsp_valid && dc_rsp_valid) begin
               checks++; errors++;
               $display("FAIL rsp_both: both rsp_valid high (cycle %0d)", cyc);
            end
            if (exp_rsps.size() == 0 || acc_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_rsp: ic %0b dc %0b with none expected (cycle %0d)", ic_rsp_valid, dc_rsp_valid, cyc);
            end else begin
               mon_r = exp_rsps.pop_front();
               mon_a = acc_q.pop_front();
               chk("rsp_owner", 128'({ic_rsp_valid, dc_rsp_valid}), 128'({!mon_r.dc, mon_r.dc}));
               chk("rsp_data", mon_r.dc ? dc_rsp_data : ic_rsp_data, mon_r.data);
               chk("rsp_latency", 128'(cyc - mon_a), 128'(mon_r.lat));
               held_dc = mon_r.dc;
               held    = mon_r.data;
            end
            busy = 1'b0;
         end
         if ((ic_req_valid && ic_req_ready) || (dc_req_valid && dc_req_ready)) begin
            acc_q.push_back(cyc);
            busy    = 1'b1;
            last_dc = dc_req_valid && dc_req_ready;
            n_acc++;
         end
      end
   end

   task automatic push_exp(input vec_t v);
      logic [31:0] base;
      base = v.addr & ~32'hF;
      for (int i = 0; i < 4; i++) exp_beats.push_back('{base + 32'(4 * i), v.we, v.wdata[32*i +: 32]});
      exp_rsps.push_back('{v.dc, v.lat, v.rdata});
   endtask

   task automatic wait_accept(input logic dc);
      int   t;
      logic acc;
      t = 0;
      do begin
         @(negedge clk);
         t++;
         acc = dc ? (dc_req_valid && dc_req_ready) : (ic_req_valid && ic_req_ready);
      end while (!acc && t < 50);
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL accept_timeout: requester dc=%0b not granted within %0d cycles", dc, t);
      end
      @(posedge clk); #1;
      if (dc) dc_req_valid = 1'b0; else ic_req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((busy || exp_rsps.size() != 0) && t < 300) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (t >= 300) begin
         errors++;
         $display("FAIL idle_timeout: transaction open after %0d cycles, %0d responses pending", t, exp_rsps.size());
         exp_rsps.delete(); exp_beats.delete(); acc_q.delete(); busy = 1'b0;
      end
      @(posedge clk); #1;
   endtask

   task automatic run_vec(input vec_t v);
      push_exp(v);
      stall_left = v.stall;
      spur_en    = v.spur;
      if (v.dc) begin
         dc_req_addr = v.addr; dc_req_we = v.we; dc_req_wdata = v.wdata; dc_req_valid = 1'b1;
      end else begin
         ic_req_addr = v.addr; ic_req_valid = 1'b1;
      end
      wait_accept(v.dc);
      wait_idle();
      spur_en = 1'b0;
   endtask

   initial begin
      vec_t vi, vd, vr;
      int   t, a0;
      vecs[0] = '{1'b0, 1'b0, 32'h0000_1238, 128'h0, 0, 1'b0, 9,
                  128'h0000123C_00001238_00001234_00001230};
      vecs[1] = '{1'b1, 1'b1, 32'h0000_2000, 128'h000000A3_000000A2_000000A1_000000A0, 0, 1'b0, 5, 128'h0};
      vecs[2] = '{1'b1, 1'b0, 32'h0000_4F07, 128'h0, 0, 1'b0, 9,
                  128'h00004F0C_00004F08_00004F04_00004F00};
      vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 128'h0, 0, 1'b0, 9,
                  128'hFFFFFFFC_FFFFFFF8_FFFFFFF4_FFFFFFF0};
      vecs[4] = '{1'b1, 1'b1, 32'h8000_0010, 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000, 3, 1'b0, 8, 128'h0};
      vecs[5] = '{1'b0, 1'b0, 32'h0000_1230, 128'h0, 3, 1'b1, 12,
                  128'h0000123C_00001238_00001234_00001230};
      vecs[6] = '{1'b1, 1'b1, 32'h0ABC_DEF5, 128'h11223344_55667788_99AABBCC_DDEEFF00, 0, 1'b0, 5, 128'h0};

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      // Both requesters held valid from reset: grants alternate I, D, I, D.
      vi = '{1'b0, 1'b0, 32'h0000_0100, 128'h0, 0, 1'b0, 9, addr_line(32'h0000_0100)};
      vd = '{1'b1, 1'b0, 32'h0000_0200, 128'h0, 0, 1'b0, 9, addr_line(32'h0000_0200)};
      rst_n = 1'b0;
      ic_req_addr = vi.addr; ic_req_valid = 1'b1;
      dc_req_addr = vd.addr; dc_req_we = 1'b0; dc_req_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      push_exp(vi); push_exp(vd); push_exp(vi); push_exp(vd);
      a0 = n_acc;
      rst_n = 1'b1;
      t = 0;
      while (n_acc < a0 + 4 && t < 400) begin
         @(negedge clk);
         t++;
      end
      @(posedge clk); #1;
      ic_req_valid = 1'b0; dc_req_valid = 1'b0;
      wait_idle();

      // Reset while waiting on read beat 2: transaction dropped, then a fresh refill.
      vr = '{1'b0, 1'b0, 32'h0000_3000, 128'h0, 0, 1'b0, 9, addr_line(32'h0000_3000)};
      push_exp(vr);
      ic_req_addr = vr.addr; ic_req_valid = 1'b1;
      wait_accept(1'b0);
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!(mem_valid && mem_addr == 32'h0000_3008) && t < 50);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("rst_async_strobes", 128'({mem_valid, ic_rsp_valid, dc_rsp_valid, ic_req_ready}), 128'(0));
      chk("rst_async_mem_addr", 128'(mem_addr), 128'(0));
      chk("rst_async_rsp_data", ic_rsp_data, 128'(0));
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      run_vec(vecs[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: simulation did not complete");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mms_mem_arb.md
MMS_MEM_ARB -- requirements
Module: mms_mem_arb

Interface
REQ-001 Parameter ADDR_WD, default 32, byte-address width.
REQ-002 Parameter DATA_WD, default 32, memory beat width.
REQ-003 Parameter BEATS, default 4, beats per cache line (16-byte line, 4-bit offset).
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 ic_req_valid  in  1  I-cache line refill request.
REQ-007 ic_req_ready  out  1  I-cache request accepted this cycle.
REQ-008 ic_req_addr  in  ADDR_WD  I-cache miss address.
REQ-009 ic_rsp_valid  out  1  one-cycle refill-complete pulse.
REQ-010 ic_rsp_data  out  BEATS*DATA_WD  refilled line (4x32 instruction set).
REQ-011 dc_req_valid / dc_req_ready  in / out  1  D-cache request handshake.
REQ-012 dc_req_addr  in  ADDR_WD  D-cache line address.
REQ-013 dc_req_we  in  1  1 = writeback of dirty line, 0 = refill.
REQ-014 dc_req_wdata  in  BEATS*DATA_WD  writeback line data.
REQ-015 dc_rsp_valid  out  1  one-cycle completion pulse; dc_rsp_data  out  BEATS*DATA_WD  refill data.
REQ-016 mem_valid / mem_ready  out / in  1  memory beat request handshake.
REQ-017 mem_addr  out  ADDR_WD; mem_we  out  1; mem_wdata  out  DATA_WD  beat address/direction/data.
REQ-018 mem_rvalid  in  1; mem_rdata  in  DATA_WD  read-beat return.

Function
REQ-019 FSM states: IDLE, REQ, WAIT, RESP.
REQ-020 IDLE: grant computed combinationally; only granted requester sees req_ready=1; accept on valid&&ready, go to REQ.
REQ-021 Single requester valid -> that requester granted; both valid -> requester not granted last (round-robin); after reset I-cache wins first tie.
REQ-022 On accept: latch owner, we (I-cache always 0), line address with bits [3:0] forced to 0, write line; clear beat counter and read buffer.
REQ-023 REQ: mem_valid=1, mem_addr = line_addr + 4*beat, mem_we = latched we, mem_wdata = line word [32*beat+31:32*beat]; hold stable until mem_ready.
REQ-024 Write beat accepted: beat++; after beat 3 go to RESP, else stay REQ.
REQ-025 Read beat accepted: go to WAIT; at most one outstanding read.
REQ-026 WAIT: mem_valid=0; on mem_rvalid store mem_rdata into word slot beat, beat++; beat 3 -> RESP, else REQ; mem_rvalid in any other state ignored.
REQ-027 Beat counter 2 bits, wraps to 0 on entering RESP; mem_addr increment never carries into bits above [3:0] because base offset is 0.
REQ-028 RESP: owner's rsp_valid=1 for exactly one cycle, rsp_data = assembled line (all zero for writeback); then IDLE; no req_ready in RESP.
REQ-029 rsp_data held stable until next accept; non-owner rsp_valid stays 0.
REQ-030 Latency, zero-wait memory (mem_ready=1, mem_rvalid cycle after beat): accept at cycle 0 -> read rsp_valid cycle 9, write rsp_valid cycle 5.
REQ-031 Next request accepted earliest the cycle after RESP (IDLE); back-to-back requesters alternate under contention.

Reset
REQ-032 rst_n low asynchronously forces IDLE, beat=0, last-grant=D-cache, buffers 0, all outputs 0 (req_ready recomputed in IDLE from valids after release).
REQ-033 Reset mid-burst drops the transaction: no rsp_valid, no further mem_valid; requester must re-issue.

Verification
REQ-034 I refill addr 0x0000_1238, zero-wait memory returning addr-as-data -> mem_addr 0x1230,0x1234,0x1238,0x123C; ic_rsp_valid cycle 9, data {0x123C,0x1238,0x1234,0x1230}.
REQ-035 D writeback addr 0x2000, wdata words 0xA0..0xA3, mem_ready=1 -> 4 write beats consecutive cycles, dc_rsp_valid cycle 5, dc_rsp_data 0.
REQ-036 Both valid continuously from reset -> grant order I, D, I, D; each rsp_valid only to owner.
REQ-037 mem_ready low 3 cycles on beat 1 -> mem_addr/mem_wdata stable throughout, latency +3; spurious mem_rvalid in REQ ignored.
REQ-038 rst_n asserted while in WAIT on beat 2 -> outputs 0 immediately, no rsp_valid; fresh request after release completes normally.
